// File: rtl/n64_bus_pkg.sv
// n64_bus_pkg: shared types, field widths and bank IDs for the cartridge memory bus
package n64_bus_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK} e_arb_state;
  localparam int BANK_W = 4;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam logic [BANK_W-1:0] BANK_INVALID    = 4'd0;
  localparam logic [BANK_W-1:0] BANK_SDRAM      = 4'd1;
  localparam logic [BANK_W-1:0] BANK_CART       = 4'd2;
  localparam logic [BANK_W-1:0] BANK_EEPROM     = 4'd3;
  localparam logic [BANK_W-1:0] BANK_FLASHRAM   = 4'd4;
  localparam logic [BANK_W-1:0] BANK_BOOTLOADER = 4'd5;
endpackage

// File: rtl/n64_bus_rr_picker.sv
// n64_bus_rr_picker: round-robin priority encoder with an optional fixed-priority override mask
module n64_bus_rr_picker #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] request,
  input  logic [W-1:0] pointer,
  input  logic [N-1:0] fixed,
  output logic [W-1:0] winner,
  output logic         valid
);
  int k;
  always_comb begin
    winner = '0;
    valid = 1'b0;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(pointer) + i) % N;
      if (request[k] && !fixed[k]) begin
        winner = W'(k);
        valid = 1'b1;
      end
    end
    // fixed-priority requesters are scanned last so they override the rotation
    for (int i = N - 1; i >= 0; i--)
      if (request[i] && fixed[i]) begin
        winner = W'(i);
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/n64_bus_arbiter.sv
// n64_bus_arbiter: serialises cartridge bus transactions from several masters onto one memory port
module n64_bus_arbiter import n64_bus_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int PI_PRIORITY = 1,
  localparam int W = $clog2(NUM_REQ)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NUM_REQ-1:0]          i_req_request,
  input  logic [NUM_REQ-1:0]          i_req_write,
  input  logic [BANK_W*NUM_REQ-1:0]   i_req_bank,
  input  logic [ADDR_W*NUM_REQ-1:0]   i_req_address,
  input  logic [DATA_W*NUM_REQ-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]          o_req_busy,
  output logic [NUM_REQ-1:0]          o_req_ack,
  output logic [DATA_W-1:0]           o_req_data,
  output logic                        o_mem_request,
  output logic                        o_mem_write,
  output logic [BANK_W-1:0]           o_mem_bank,
  output logic [ADDR_W-1:0]           o_mem_address,
  output logic [DATA_W-1:0]           o_mem_data,
  input  logic                        i_mem_busy,
  input  logic                        i_mem_ack,
  input  logic [DATA_W-1:0]           i_mem_data,
  output logic [W-1:0]                o_owner,
  output logic                        o_active
);
  localparam int FIRST_RR = (PI_PRIORITY != 0) ? 1 : 0;
  localparam logic [NUM_REQ-1:0] FIXED = (PI_PRIORITY != 0) ? NUM_REQ'(1) : '0;
  e_arb_state state, state_nx;
  logic [W-1:0] ptr, ptr_nx, win;
  logic win_ok, grant, accept, done;
  logic [DATA_W-1:0] data_q;
  n64_bus_rr_picker #(.N(NUM_REQ)) picker (
    .request(i_req_request),
    .pointer(ptr),
    .fixed(FIXED),
    .winner(win),
    .valid(win_ok)
  );
  assign grant  = state == S_IDLE && win_ok;
  assign accept = state == S_ISSUE && !i_mem_busy;
  assign done   = state == S_WAIT_ACK && i_mem_ack;
  always_comb begin
    state_nx = grant ? S_ISSUE : accept ? S_WAIT_ACK : done ? S_IDLE : state;
    ptr_nx = (PI_PRIORITY != 0 && win == '0) ? ptr :
             (win == W'(NUM_REQ - 1)) ? W'(FIRST_RR) : win + W'(1);
  end
  assign o_req_busy = (grant && !i_reset) ? ~(NUM_REQ'(1) << win) : '1;
  assign o_req_ack  = (done && !i_reset) ? NUM_REQ'(1) << o_owner : '0;
  assign o_req_data = (done && !i_reset) ? i_mem_data : data_q;
  assign o_active   = state != S_IDLE;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      ptr <= W'(FIRST_RR);
      o_owner <= '0;
      o_mem_request <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_bank <= '0;
      o_mem_address <= '0;
      o_mem_data <= '0;
      data_q <= '0;
    end else begin
      if (grant) begin
        ptr <= ptr_nx;
        o_owner <= win;
        o_mem_request <= 1'b1;
        o_mem_write <= i_req_write[win];
        o_mem_bank <= i_req_bank[BANK_W*int'(win) +: BANK_W];
        o_mem_address <= i_req_address[ADDR_W*int'(win) +: ADDR_W];
        o_mem_data <= i_req_data[DATA_W*int'(win) +: DATA_W];
      end else if (accept) begin
        o_mem_request <= 1'b0;
        o_mem_write <= 1'b0;
      end
      if (done) data_q <= i_mem_data;
    end
endmodule

// File: tb/tb_n64_bus_arbiter.sv
// tb_n64_bus_arbiter: directed and randomized checks of the bus arbiter against a reference model
module tb_n64_bus_arbiter;
  localparam int N = 4;
  localparam int PI = 1;
  logic clk = 1'b0;
  logic i_reset;
  logic [N-1:0] req_request, req_write, o_req_busy, o_req_ack;
  logic [4*N-1:0] req_bank;
  logic [26*N-1:0] req_address;
  logic [32*N-1:0] req_data;
  logic [31:0] o_req_data, o_mem_data, i_mem_data;
  logic o_mem_request, o_mem_write, i_mem_busy, i_mem_ack, o_active;
  logic [3:0] o_mem_bank;
  logic [25:0] o_mem_address;
  logic [1:0] o_owner;
  int n_tests = 0, n_fail = 0;
  bit req_v [N];
  logic wr [N];
  logic [3:0] bk [N];
  logic [25:0] ad [N];
  logic [31:0] dt [N];
  int rr_next = 1;
  int exp_rr [6] = '{1, 2, 3, 1, 2, 3};

  always #5 clk = ~clk;

  n64_bus_arbiter #(.NUM_REQ(N), .PI_PRIORITY(PI)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req_request(req_request), .i_req_write(req_write), .i_req_bank(req_bank),
    .i_req_address(req_address), .i_req_data(req_data),
    .o_req_busy(o_req_busy), .o_req_ack(o_req_ack), .o_req_data(o_req_data),
    .o_mem_request(o_mem_request), .o_mem_write(o_mem_write), .o_mem_bank(o_mem_bank),
    .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
    .i_mem_busy(i_mem_busy), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .o_owner(o_owner), .o_active(o_active)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push();
    for (int j = 0; j < N; j++) begin
      req_request[j] = req_v[j];
      req_write[j] = wr[j];
      req_bank[4*j +: 4] = bk[j];
      req_address[26*j +: 26] = ad[j];
      req_data[32*j +: 32] = dt[j];
    end
  endtask

  task automatic set_req(input int j, input logic w, input logic [3:0] b, input logic [25:0] a, input logic [31:0] d);
    req_v[j] = 1'b1; wr[j] = w; bk[j] = b; ad[j] = a; dt[j] = d;
  endtask

  // requester 0 preempts when PI=1; otherwise the first requester at or after rr_next wins
  function automatic int model_pick();
    if (PI != 0 && req_v[0]) return 0;
    for (int k = 0; k < N; k++) begin
      int j = (rr_next + k) % N;
      if (req_v[j] && !(PI != 0 && j == 0)) return j;
    end
    return -1;
  endfunction

  // starts and ends at a negedge with the arbiter idle
  task automatic txn(input int bcyc, input int lat, input logic [31:0] rdata);
    int w;
    logic ew;
    logic [3:0] eb;
    logic [25:0] ea;
    logic [31:0] ed;
    logic [N-1:0] ebusy, eack;
    push();
    #1;
    w = model_pick();
    ebusy = '1;
    if (w >= 0) ebusy[w] = 1'b0;
    chk("busy_idle", 32'(o_req_busy), 32'(ebusy));
    if (w < 0) begin
      i_mem_ack = 1'b1;
      #1;
      chk("ack_spurious_idle", 32'(o_req_ack), 32'd0);
      i_mem_ack = 1'b0;
      @(negedge clk);
    end else begin
      ew = wr[w]; eb = bk[w]; ea = ad[w]; ed = dt[w];
      eack = '0;
      eack[w] = 1'b1;
      req_v[w] = 1'b0;
      if (!(PI != 0 && w == 0)) rr_next = (w + 1 == N) ? ((PI != 0) ? 1 : 0) : w + 1;
      @(negedge clk);
      wr[w] = 1'($urandom); bk[w] = 4'($urandom); ad[w] = 26'($urandom); dt[w] = $urandom;
      push();
      #1;
      chk("owner", 32'(o_owner), 32'(w));
      chk("issue_req", 32'(o_mem_request), 32'd1);
      chk("issue_write", 32'(o_mem_write), 32'(ew));
      chk("issue_bank", 32'(o_mem_bank), 32'(eb));
      chk("issue_addr", 32'(o_mem_address), 32'(ea));
      chk("issue_data", o_mem_data, ed);
      chk("issue_active", 32'(o_active), 32'd1);
      chk("issue_busy", 32'(o_req_busy), 32'(4'hF));
      i_mem_busy = 1'b1;
      repeat (bcyc) begin
        i_mem_ack = 1'($urandom);
        #1;
        chk("hold_req", 32'(o_mem_request), 32'd1);
        chk("hold_addr", 32'(o_mem_address), 32'(ea));
        chk("hold_data", o_mem_data, ed);
        chk("ack_spurious_issue", 32'(o_req_ack), 32'd0);
        @(negedge clk);
      end
      i_mem_ack = 1'b0;
      i_mem_busy = 1'b0;
      @(negedge clk);
      #1;
      chk("wait_req", 32'(o_mem_request), 32'd0);
      chk("wait_write", 32'(o_mem_write), 32'd0);
      chk("wait_active", 32'(o_active), 32'd1);
      repeat (lat) begin
        chk("wait_noack", 32'(o_req_ack), 32'd0);
        @(negedge clk);
      end
      i_mem_ack = 1'b1;
      i_mem_data = rdata;
      #1;
      chk("ack_route", 32'(o_req_ack), 32'(eack));
      chk("ack_data", o_req_data, rdata);
      @(negedge clk);
      i_mem_ack = 1'b0;
      i_mem_data = ~rdata;
      #1;
      chk("ack_done", 32'(o_req_ack), 32'd0);
      chk("data_hold", o_req_data, rdata);
      chk("idle_active", 32'(o_active), 32'd0);
    end
  endtask

  initial begin
    for (int j = 0; j < N; j++) begin
      req_v[j] = 1'b0; wr[j] = 1'b0; bk[j] = '0; ad[j] = '0; dt[j] = '0;
    end
    push();
    i_reset = 1'b1; i_mem_busy = 1'b0; i_mem_ack = 1'b0; i_mem_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(o_req_busy), 32'(4'hF));
    chk("rst_ack", 32'(o_req_ack), 32'd0);
    chk("rst_mem_req", 32'(o_mem_request), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_address), 32'd0);
    chk("rst_owner", 32'(o_owner), 32'd0);
    chk("rst_active", 32'(o_active), 32'd0);
    i_reset = 1'b0;
    @(negedge clk);

    set_req(0, 1'b0, 4'd1, 26'h0000100, 32'h0);
    txn(0, 0, 32'hDEADBEEF);
    set_req(1, 1'b1, 4'd2, 26'h3FFFFFC, 32'h12345678);
    txn(5, 1, 32'h0BADF00D);
    chk("write_owner", 32'(o_owner), 32'd1);

    set_req(0, 1'b0, 4'd1, 26'h10, 32'h0);
    set_req(2, 1'b0, 4'd1, 26'h20, 32'h0);
    set_req(3, 1'b1, 4'd3, 26'h30, 32'hA5A5A5A5);
    txn(0, 0, 32'h11111111);
    chk("order_0", 32'(o_owner), 32'd0);
    txn(1, 0, 32'h22222222);
    chk("order_2", 32'(o_owner), 32'd2);
    set_req(0, 1'b1, 4'd4, 26'h40, 32'h44444444);
    txn(0, 2, 32'h33333333);
    chk("order_0b", 32'(o_owner), 32'd0);
    txn(0, 0, 32'h55555555);
    chk("order_3", 32'(o_owner), 32'd3);

    for (int r = 0; r < 6; r++) begin
      for (int j = 1; j < N; j++)
        if (!req_v[j]) set_req(j, 1'(r & 1), 4'(j), 26'(r * 16 + j), $urandom);
      txn(r % 3, 0, $urandom);
      chk("rr_order", 32'(o_owner), 32'(exp_rr[r]));
    end

    for (int r = 0; r < 30; r++) begin
      for (int j = 0; j < N; j++)
        if (!req_v[j] && $urandom_range(0, 2) == 0)
          set_req(j, 1'($urandom), 4'($urandom), 26'($urandom), $urandom);
      txn($urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end

    for (int j = 0; j < N; j++) req_v[j] = 1'b0;
    set_req(2, 1'b0, 4'd3, 26'h2AAAAAA, 32'h0);
    push();
    #1;
    chk("abort_grant", 32'(o_req_busy), 32'(4'b1011));
    @(negedge clk);
    chk("abort_issue", 32'(o_mem_request), 32'd1);
    req_v[2] = 1'b0;
    push();
    @(negedge clk);
    chk("abort_wait", 32'(o_active), 32'd1);
    set_req(3, 1'b0, 4'd1, 26'h3, 32'h0);
    push();
    i_reset = 1'b1;
    i_mem_ack = 1'b1;
    #1;
    chk("abort_rst_busy", 32'(o_req_busy), 32'(4'hF));
    chk("abort_rst_ack", 32'(o_req_ack), 32'd0);
    chk("abort_rst_active", 32'(o_active), 32'd0);
    chk("abort_rst_req", 32'(o_mem_request), 32'd0);
    chk("abort_rst_owner", 32'(o_owner), 32'd0);
    @(negedge clk);
    req_v[3] = 1'b0;
    push();
    i_reset = 1'b0;
    #1;
    chk("late_ack", 32'(o_req_ack), 32'd0);
    @(negedge clk);
    i_mem_ack = 1'b0;
    #1;
    chk("late_active", 32'(o_active), 32'd0);
    chk("late_req", 32'(o_mem_request), 32'd0);
    rr_next = 1;
    set_req(2, 1'b0, 4'd1, 26'h222, 32'h0);
    set_req(3, 1'b0, 4'd1, 26'h333, 32'h0);
    txn(0, 0, 32'hCAFEF00D);
    chk("ptr_after_rst", 32'(o_owner), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/n64_bus_arbiter.md
Name: n64_bus_arbiter

Overview:
- Shares the single cartridge memory bus between several masters: the N64 PI front-end (requester 0), USB, SD and flashram DMA engines.
- Sits between the requesters and the memory/bank controller.
- Requester-side handshake is identical to the PI bus interface: request / busy / ack, 26-bit address, 4-bit bank, 32-bit data.
- Serialises transactions with one outstanding at a time, and routes the completion ack and read data back to the owner.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PI_PRIORITY, 1, when 1 requester 0 has fixed top priority; when 0 all requesters are round-robin.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_request  in  NUM_REQ  per-requester request, held until accepted.
- i_req_write  in  NUM_REQ  per-requester write flag.
- i_req_bank  in  4*NUM_REQ  per-requester bank, slice [4i+3:4i].
- i_req_address  in  26*NUM_REQ  per-requester address.
- i_req_data  in  32*NUM_REQ  per-requester write data.
- o_req_busy  out  NUM_REQ  deasserted only for the requester being accepted this cycle.
- o_req_ack  out  NUM_REQ  one-cycle completion pulse to the owner.
- o_req_data  out  32  read data, broadcast, valid with o_req_ack.
- o_mem_request  out  1  downstream request.
- o_mem_write  out  1  downstream write flag.
- o_mem_bank  out  4  downstream bank.
- o_mem_address  out  26  downstream address.
- o_mem_data  out  32  downstream write data.
- i_mem_busy  in  1  downstream busy; the request is accepted when o_mem_request && !i_mem_busy.
- i_mem_ack  in  1  downstream completion, one pulse per transaction (reads and writes).
- i_mem_data  in  32  downstream read data, valid with i_mem_ack.
- o_owner  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- o_active  out  1  high in ISSUE or WAIT_ACK.

Behaviour:
- Reset (asynchronous): state IDLE, o_mem_* = 0, o_owner = 0, round-robin pointer = 1 (or 0 if PI_PRIORITY=0). While i_reset is high, o_req_busy is all ones and o_req_ack is 0.
- States:
  - IDLE: select a winner combinationally from i_req_request. o_req_busy[winner] = 0, all others 1. On the clock edge, latch the winner's write/bank/address/data into o_mem_*, set o_owner, set o_mem_request = 1, go to ISSUE. With no request, stay in IDLE and keep all busy = 0? No: o_req_busy = all ones except the winner, so with no request every busy bit is 1.
  - ISSUE: o_mem_request is high, and o_mem_* are stable until acceptance. On !i_mem_busy, drop o_mem_request and o_mem_write next cycle and go to WAIT_ACK. i_mem_ack in ISSUE is ignored; memory guarantees ack at least 1 cycle after acceptance.
  - WAIT_ACK: on i_mem_ack, o_req_ack[o_owner] = i_mem_ack and o_req_data = i_mem_data, combinational and in the same cycle. Go to IDLE on the same edge.
- Arbitration:
  - PI_PRIORITY=1: requester 0 always wins if requesting. Otherwise round-robin over 1..NUM_REQ-1, starting at the pointer.
  - PI_PRIORITY=0: round-robin over all requesters.
  - The pointer updates on each grant to (winner+1) mod range. A requester 0 grant does not move the pointer when PI_PRIORITY=1.
- Timing:
  - Accept to o_mem_request: 1 cycle.
  - Minimum turnaround is 3 cycles plus memory latency. A new grant is possible in the cycle IDLE is re-entered.
- Requesters must hold request and command fields stable until busy=0. A withdrawn request is simply not granted and raises no error.
- A spurious i_mem_ack in IDLE or ISSUE produces no o_req_ack.
- o_req_data holds its last value when no ack is present; it is not zeroed.
- Reset mid-transaction aborts it. An ack arriving after reset is ignored because the state is IDLE.

Decomposition:
- Shared package n64_bus_pkg:
  - state enum e_arb_state {S_IDLE, S_ISSUE, S_WAIT_ACK}.
  - Constants BANK_W=4, ADDR_W=26, DATA_W=32.
  - Bank ID constants shared with the bank decoder.
- Sub-module n64_bus_rr_picker: combinational round-robin priority encoder. Inputs: request vector, pointer, and mask of the fixed-priority bit. Outputs: winner index and valid.

Test Plan:
- Single read: req0 with bank 1, address 0x0000100, write 0 → busy[0]=0 for 1 cycle. o_mem_request=1 next cycle with address 0x0000100. Memory returns 0xDEADBEEF → o_req_ack[0] pulses with o_req_data = 0xDEADBEEF.
- Simultaneous req0, req2, req3, PI_PRIORITY=1 → grant order 0, 2, 3. Re-asserting req0 during the grant to 2 makes order 0, 2, 0, 3.
- Round-robin: req1..3 continuously asserted → grants 1, 2, 3, 1, 2, 3 with no repeats. Acks are routed to the matching index each time.
- Downstream busy held 5 cycles in ISSUE → o_mem_request, address and data remain constant. WAIT_ACK is entered on the first !busy cycle.
- Write from req1 with data 0x12345678, address 0x3FFFFFC, bank 2 → o_mem_write=1 and fields are passed through exactly. The write ack routes to ack[1].
- i_reset asserted in WAIT_ACK, then i_mem_ack after release → o_mem_request=0, o_active=0, no o_req_ack pulse.
